// File: rtl/vga_pkg.sv
// Shared VGA-chain definitions: font geometry, text slot attributes and
// configuration selector codes used by the text overlay.
package vga_pkg;

  localparam int FONT_W = 8;
  localparam int FONT_H = 16;

  localparam logic CFG_CHAR = 1'b0;
  localparam logic CFG_ATTR = 1'b1;

  // Field order matches cfg_data[47:5] of an attribute write.
  typedef struct packed {
    logic        en;
    logic        blink;
    logic [1:0]  scale_log2;
    logic [11:0] colour;
    logic [10:0] x;
    logic [10:0] y;
    logic [4:0]  len;
  } text_attr_t;

  // Oversized lengths are pinned to the slot capacity on the way in.
  function automatic text_attr_t clamp_len(input text_attr_t attr, input int max_chars);
    text_attr_t res;
    res = attr;
    if (int'(attr.len) > max_chars) res.len = 5'(max_chars);
    return res;
  endfunction

endpackage

// File: rtl/vga_intf.sv
// VGA pixel-chain bundle: timing counters, sync/blank flags and 12-bit rgb.
interface vga_intf;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/delay.sv
// Fixed-latency shift register with synchronous clear.
module delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] delayed
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  // Shift the value through CLK_DEL register stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= value;
      for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign delayed = pipe[CLK_DEL-1];

endmodule

// File: rtl/font_rom.sv
// 8x16 glyph ROM with one cycle of read latency. 'A' and 'B' carry real
// glyph shapes; every other code (including 0x00) reads back a solid block.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] row);
    logic [7:0] bits;
    bits = 8'hFF;
    if (code == 7'h41) begin
      case (row)
        4'd2:                               bits = 8'h10;
        4'd3:                               bits = 8'h38;
        4'd4:                               bits = 8'h6C;
        4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: bits = 8'hC6;
        4'd7:                               bits = 8'hFE;
        default:                            bits = 8'h00;
      endcase
    end else if (code == 7'h42) begin
      case (row)
        4'd2, 4'd11:                               bits = 8'hFC;
        4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10: bits = 8'h66;
        4'd6:                                      bits = 8'h7C;
        default:                                   bits = 8'h00;
      endcase
    end
    return bits;
  endfunction

  // Registered read, {code, row} addressing.
  always_ff @(posedge clk) begin
    data <= glyph_row(addr[10:4], addr[3:0]);
  end

endmodule

// File: rtl/text_slot_hit.sv
// Per-slot hit test: decides whether the current pixel falls inside one
// slot's scaled text box and returns the character index, glyph row and
// glyph column for it. All arithmetic is 12-bit unsigned so positions near
// the right/bottom screen edge never wrap.
module text_slot_hit
  import vga_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             en,
  input  logic             suppress,
  input  logic [1:0]       scale_log2,
  input  logic [10:0]      x,
  input  logic [10:0]      y,
  input  logic [4:0]       len,
  input  logic [10:0]      hcount,
  input  logic [10:0]      vcount,
  output logic             hit,
  output logic [IDX_W-1:0] index,
  output logic [3:0]       row,
  output logic [2:0]       col
);

  logic [11:0] h12, v12, x12, y12;
  logic [11:0] dx, dy;
  logic [11:0] width, height;

  assign h12 = {1'b0, hcount};
  assign v12 = {1'b0, vcount};
  assign x12 = {1'b0, x};
  assign y12 = {1'b0, y};

  assign dx = h12 - x12;
  assign dy = v12 - y12;

  assign width  = ({7'd0, len} * 12'(FONT_W)) << scale_log2;
  assign height = 12'(FONT_H) << scale_log2;

  assign hit = en && !suppress && (h12 >= x12) && (v12 >= y12) &&
               (dx < width) && (dy < height);

  // Glyphs are FONT_W wide before scaling, so the character index drops
  // three extra bits on top of the scale shift.
  assign index = IDX_W'(dx >> (4'd3 + {2'b00, scale_log2}));
  assign row   = 4'(dy >> scale_log2);
  assign col   = 3'(dx >> scale_log2);

endmodule

// File: rtl/draw_text_overlay.sv
// Text overlay stage: NUM_SLOTS programmable strings drawn over the
// upstream picture. Config lands in shadow storage and is copied to the
// active set at each vblnk rise, so a frame is always drawn from one
// consistent configuration. Output is the input delayed by two cycles.
module draw_text_overlay
  import vga_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int MAX_CHARS    = 16,
  parameter int BLINK_FRAMES = 30,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int IDX_W  = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_sel,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [47:0]       cfg_data,
  vga_intf.in               vga_in,
  vga_intf.out              vga_out
);

  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TIM_W  = 26;

  text_attr_t  shadow_attr [NUM_SLOTS];
  text_attr_t  active_attr [NUM_SLOTS];
  logic [6:0]  shadow_char [NUM_SLOTS][MAX_CHARS];
  logic [6:0]  active_char [NUM_SLOTS][MAX_CHARS];

  logic              vblnk_q;
  logic              frame_start;
  logic              cfg_fire;
  logic              slot_ok;
  logic              idx_ok;
  logic [FCNT_W-1:0] frame_cnt;
  logic              blink_phase;

  assign frame_start = vga_in.vblnk && !vblnk_q;
  assign cfg_ready   = !frame_start;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign slot_ok     = {1'b0, cfg_slot} < (SLOT_W+1)'(NUM_SLOTS);
  assign idx_ok      = {1'b0, cfg_idx} < (IDX_W+1)'(MAX_CHARS);

  // Registered vblnk for rising-edge (frame start) detection.
  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vga_in.vblnk;
  end

  // Shadow storage: accepted writes to nonexistent slots are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        shadow_attr[s] <= '0;
        for (int c = 0; c < MAX_CHARS; c++) shadow_char[s][c] <= '0;
      end
    end else if (cfg_fire && slot_ok) begin
      if (cfg_sel == CFG_ATTR)
        shadow_attr[cfg_slot] <= clamp_len(text_attr_t'(cfg_data[47:5]), MAX_CHARS);
      else if (idx_ok)
        shadow_char[cfg_slot][cfg_idx] <= cfg_data[6:0];
    end
  end

  // Atomic commit of the whole shadow set at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        active_attr[s] <= '0;
        for (int c = 0; c < MAX_CHARS; c++) active_char[s][c] <= '0;
      end
    end else if (frame_start) begin
      active_attr <= shadow_attr;
      active_char <= shadow_char;
    end
  end

  // Frame counter and blink phase, toggling every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FCNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [NUM_SLOTS-1:0] slot_hit;
  logic [IDX_W-1:0]     slot_index [NUM_SLOTS];
  logic [3:0]           slot_row   [NUM_SLOTS];
  logic [2:0]           slot_col   [NUM_SLOTS];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    text_slot_hit #(.IDX_W(IDX_W)) u_hit (
      .en         (active_attr[s].en),
      .suppress   (active_attr[s].blink && blink_phase),
      .scale_log2 (active_attr[s].scale_log2),
      .x          (active_attr[s].x),
      .y          (active_attr[s].y),
      .len        (active_attr[s].len),
      .hcount     (vga_in.hcount),
      .vcount     (vga_in.vcount),
      .hit        (slot_hit[s]),
      .index      (slot_index[s]),
      .row        (slot_row[s]),
      .col        (slot_col[s])
    );
  end

  logic        sel_hit;
  logic [11:0] sel_colour;
  logic [6:0]  sel_char;
  logic [3:0]  sel_row;
  logic [2:0]  sel_col;

  // Priority select: walking down from the top index lets the lowest hit win.
  always_comb begin
    sel_hit    = 1'b0;
    sel_colour = '0;
    sel_char   = '0;
    sel_row    = '0;
    sel_col    = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (slot_hit[s]) begin
        sel_hit    = 1'b1;
        sel_colour = active_attr[s].colour;
        sel_char   = active_char[s][slot_index[s]];
        sel_row    = slot_row[s];
        sel_col    = slot_col[s];
      end
    end
  end

  logic [7:0] rom_data;

  font_rom u_font_rom (
    .clk  (clk),
    .addr ({sel_char, sel_row}),
    .data (rom_data)
  );

  logic        s1_hit;
  logic [11:0] s1_colour;
  logic [2:0]  s1_col;
  logic        s1_char_zero;
  logic [11:0] s1_rgb;
  logic        s1_blank;
  logic [11:0] rgb_q;

  // Stage 1: pixel context aligned with the ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit       <= 1'b0;
      s1_colour    <= '0;
      s1_col       <= '0;
      s1_char_zero <= 1'b1;
      s1_rgb       <= '0;
      s1_blank     <= 1'b0;
    end else begin
      s1_hit       <= sel_hit;
      s1_colour    <= sel_colour;
      s1_col       <= sel_col;
      s1_char_zero <= (sel_char == 7'd0);
      s1_rgb       <= vga_in.rgb;
      s1_blank     <= vga_in.hblnk || vga_in.vblnk;
    end
  end

  // Stage 2: blanking forces black; code 0x00 never draws.
  always_ff @(posedge clk) begin
    if (rst)
      rgb_q <= '0;
    else if (s1_blank)
      rgb_q <= '0;
    else if (s1_hit && !s1_char_zero && rom_data[3'd7 - s1_col])
      rgb_q <= s1_colour;
    else
      rgb_q <= s1_rgb;
  end

  logic [TIM_W-1:0] tim_delayed;

  delay #(.WIDTH(TIM_W), .CLK_DEL(2)) u_tim_delay (
    .clk     (clk),
    .rst     (rst),
    .value   ({vga_in.hcount, vga_in.vcount, vga_in.hsync,
               vga_in.vsync, vga_in.hblnk, vga_in.vblnk}),
    .delayed (tim_delayed)
  );

  assign {vga_out.hcount, vga_out.vcount, vga_out.hsync,
          vga_out.vsync, vga_out.hblnk, vga_out.vblnk} = tim_delayed;
  assign vga_out.rgb = rgb_q;

endmodule

// File: tb/tb_draw_text_overlay.sv
// Directed bench for draw_text_overlay, built with BLINK_FRAMES=2.
module tb_draw_text_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_sel;
  logic [1:0]  cfg_slot;
  logic [3:0]  cfg_idx;
  logic [47:0] cfg_data;
  int          checks   = 0;
  int          failures = 0;
  int          nframes  = 0;

  vga_intf vin ();
  vga_intf vout ();

  draw_text_overlay #(
    .NUM_SLOTS    (4),
    .MAX_CHARS    (16),
    .BLINK_FRAMES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sel   (cfg_sel),
    .cfg_slot  (cfg_slot),
    .cfg_idx   (cfg_idx),
    .cfg_data  (cfg_data),
    .vga_in    (vin),
    .vga_out   (vout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] mk_attr(input logic en, input logic blink,
                                          input logic [1:0] sc, input logic [11:0] colour,
                                          input logic [10:0] x, input logic [10:0] y,
                                          input logic [4:0] len);
    return {en, blink, sc, colour, x, y, len, 5'd0};
  endfunction

  task automatic drive(input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] c, input logic blank);
    vin.hcount = h;
    vin.vcount = v;
    vin.rgb    = c;
    vin.hblnk  = blank;
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] slot, input logic [3:0] idx,
                           input logic [47:0] data, input string tag);
    bit done;
    done = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_slot  = slot;
    cfg_idx   = idx;
    cfg_data  = data;
    for (int i = 0; i < 8 && !done; i++) begin
      #1;
      if (cfg_ready) begin
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    check({tag, "_accepted"}, {47'd0, done}, 48'd1);
  endtask

  task automatic wr_char(input logic [1:0] slot, input logic [3:0] idx, input logic [6:0] code);
    cfg_write(1'b0, slot, idx, {41'd0, code}, "char_wr");
  endtask

  task automatic frame_start();
    @(negedge clk);
    vin.vblnk = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin.vblnk = 1'b0;
    @(posedge clk);
    nframes++;
  endtask

  // Present one pixel, replace it with a filler after the first edge, and
  // check the output exactly two edges after the pixel was sampled.
  task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] bg, input logic blank, input logic [11:0] exp);
    @(negedge clk);
    drive(h, v, bg, blank);
    @(posedge clk);
    #1;
    drive(11'd0, 11'd0, 12'h123, 1'b0);
    @(posedge clk);
    #1;
    check(tag, {36'd0, vout.rgb}, {36'd0, exp});
    check({tag, "_h"}, {37'd0, vout.hcount}, {37'd0, h});
  endtask

  initial begin
    logic [11:0] blink_exp;

    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_sel   = 1'b0;
    cfg_slot  = '0;
    cfg_idx   = '0;
    cfg_data  = '0;
    vin.hsync = 1'b0;
    vin.vsync = 1'b0;
    vin.vblnk = 1'b0;
    drive(11'd0, 11'd0, 12'h123, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {36'd0, vout.rgb}, 48'd0);
    check("reset_hcount", {37'd0, vout.hcount}, 48'd0);
    check("reset_vblnk", {47'd0, vout.vblnk}, 48'd0);
    check("reset_ready", {47'd0, cfg_ready}, 48'd1);
    @(negedge clk);
    rst = 1'b0;

    // Slot 0 "AB" at (100,50), unscaled, magenta.
    wr_char(2'd0, 4'd0, 7'h41);
    wr_char(2'd0, 4'd1, 7'h42);
    cfg_write(1'b1, 2'd0, 4'd0, mk_attr(1'b1, 1'b0, 2'd0, 12'hF0F, 11'd100, 11'd50, 5'd2), "attr_ab");
    probe("precommit", 11'd100, 11'd57, 12'h555, 1'b0, 12'h555);
    frame_start();
    probe("a_row2_col3", 11'd103, 11'd52, 12'h555, 1'b0, 12'hF0F);
    probe("a_row7_col7", 11'd107, 11'd57, 12'h555, 1'b0, 12'h555);
    probe("a_row7_col0", 11'd100, 11'd57, 12'h555, 1'b0, 12'hF0F);
    probe("a_row0", 11'd100, 11'd50, 12'h555, 1'b0, 12'h555);
    probe("b_row2_col0", 11'd108, 11'd52, 12'h555, 1'b0, 12'hF0F);
    probe("b_row2_col6", 11'd114, 11'd52, 12'h555, 1'b0, 12'h555);
    probe("right_edge", 11'd116, 11'd57, 12'h555, 1'b0, 12'h555);
    probe("bottom_edge", 11'd100, 11'd66, 12'h555, 1'b0, 12'h555);
    probe("left_edge", 11'd99, 11'd57, 12'h555, 1'b0, 12'h555);
    probe("blanked", 11'd100, 11'd57, 12'h555, 1'b1, 12'h000);

    // Scale 8x, four characters "ABZZ" at (192,176): 256x128 box.
    wr_char(2'd0, 4'd2, 7'h5A);
    wr_char(2'd0, 4'd3, 7'h5A);
    cfg_write(1'b1, 2'd0, 4'd0, mk_attr(1'b1, 1'b0, 2'd3, 12'h0F0, 11'd192, 11'd176, 5'd4), "attr_x8");
    frame_start();
    probe("x8_col3", 11'd216, 11'd192, 12'h555, 1'b0, 12'h0F0);
    probe("x8_col2", 11'd215, 11'd192, 12'h555, 1'b0, 12'h555);
    probe("x8_col4", 11'd224, 11'd192, 12'h555, 1'b0, 12'h555);
    probe("x8_col0_first", 11'd192, 11'd232, 12'h555, 1'b0, 12'h0F0);
    probe("x8_col0_last", 11'd199, 11'd232, 12'h555, 1'b0, 12'h0F0);
    probe("x8_col7", 11'd248, 11'd232, 12'h555, 1'b0, 12'h555);
    probe("x8_corner", 11'd447, 11'd303, 12'h555, 1'b0, 12'h0F0);
    probe("x8_past_right", 11'd448, 11'd303, 12'h555, 1'b0, 12'h555);
    probe("x8_past_bottom", 11'd447, 11'd304, 12'h555, 1'b0, 12'h555);

    // Overlap: slot 0 red over slot 1 blue; slot 1 char 1 stays 0x00.
    wr_char(2'd0, 4'd0, 7'h5A);
    wr_char(2'd1, 4'd0, 7'h5A);
    cfg_write(1'b1, 2'd0, 4'd0, mk_attr(1'b1, 1'b0, 2'd0, 12'hF00, 11'd400, 11'd300, 5'd1), "attr_ov0");
    cfg_write(1'b1, 2'd1, 4'd0, mk_attr(1'b1, 1'b0, 2'd0, 12'h00F, 11'd400, 11'd300, 5'd2), "attr_ov1");
    frame_start();
    probe("overlap_slot0", 11'd403, 11'd305, 12'h555, 1'b0, 12'hF00);
    probe("code0_transparent", 11'd408, 11'd305, 12'h555, 1'b0, 12'h555);
    cfg_write(1'b1, 2'd0, 4'd0, mk_attr(1'b0, 1'b0, 2'd0, 12'hF00, 11'd400, 11'd300, 5'd1), "attr_off0");
    frame_start();
    probe("overlap_slot1", 11'd403, 11'd305, 12'h555, 1'b0, 12'h00F);

    // Mid-frame write only shows after the next commit.
    @(negedge clk);
    drive(11'd50, 11'd200, 12'h555, 1'b0);
    cfg_write(1'b1, 2'd1, 4'd0, mk_attr(1'b1, 1'b0, 2'd0, 12'h0FF, 11'd400, 11'd300, 5'd2), "attr_mid");
    probe("midframe_old", 11'd403, 11'd305, 12'h555, 1'b0, 12'h00F);
    frame_start();
    probe("midframe_new", 11'd403, 11'd305, 12'h555, 1'b0, 12'h0FF);

    // Write presented on the vblnk rise stalls one cycle and misses this commit.
    @(negedge clk);
    vin.vblnk = 1'b1;
    cfg_valid = 1'b1;
    cfg_sel   = 1'b1;
    cfg_slot  = 2'd1;
    cfg_data  = mk_attr(1'b1, 1'b0, 2'd0, 12'hFF0, 11'd400, 11'd300, 5'd2);
    #1;
    check("ready_commit", {47'd0, cfg_ready}, 48'd0);
    @(posedge clk);
    nframes++;
    @(negedge clk);
    #1;
    check("ready_after", {47'd0, cfg_ready}, 48'd1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    vin.vblnk = 1'b0;
    probe("stalled_old", 11'd403, 11'd305, 12'h555, 1'b0, 12'h0FF);
    frame_start();
    probe("stalled_new", 11'd403, 11'd305, 12'h555, 1'b0, 12'hFF0);

    // Blink with BLINK_FRAMES=2: visible while (frames/2) is even.
    wr_char(2'd2, 4'd0, 7'h5A);
    cfg_write(1'b1, 2'd2, 4'd0, mk_attr(1'b1, 1'b1, 2'd0, 12'h777, 11'd600, 11'd400, 5'd1), "attr_blink");
    frame_start();
    for (int f = 0; f < 5; f++) begin
      blink_exp = (((nframes / 2) % 2) == 0) ? 12'h777 : 12'h555;
      probe("blink", 11'd600, 11'd400, 12'h555, 1'b0, blink_exp);
      frame_start();
    end

    // Reset in the middle of a line.
    probe("pre_reset", 11'd403, 11'd305, 12'h555, 1'b0, 12'hFF0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_rgb", {36'd0, vout.rgb}, 48'd0);
    check("midreset_hcount", {37'd0, vout.hcount}, 48'd0);
    @(negedge clk);
    rst = 1'b0;
    nframes = 0;
    probe("post_reset", 11'd403, 11'd305, 12'hABC, 1'b0, 12'hABC);
    frame_start();
    probe("post_reset_commit", 11'd403, 11'd305, 12'hABC, 1'b0, 12'hABC);

    // len=20 is clamped to 16 characters.
    wr_char(2'd0, 4'd0, 7'h5A);
    wr_char(2'd0, 4'd15, 7'h5A);
    cfg_write(1'b1, 2'd0, 4'd0, mk_attr(1'b1, 1'b0, 2'd0, 12'h0AA, 11'd300, 11'd500, 5'd20), "attr_clamp");
    frame_start();
    probe("clamp_first", 11'd300, 11'd500, 12'h555, 1'b0, 12'h0AA);
    probe("clamp_last", 11'd420, 11'd500, 12'h555, 1'b0, 12'h0AA);
    probe("clamp_beyond", 11'd428, 11'd500, 12'h555, 1'b0, 12'h555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
